uart_rx: RTL and testbench

//  Serial-to-parallel UART receiver; receiving counterpart of UART_Tx, sharing its config encodings.

---
 rtl/uart_pkg.sv | 43 ++++
 rtl/uart_rx_baud_gen.sv | 27 ++
 rtl/uart_rx.sv | 151 +++++++++++++++
 tb/tb_uart_rx.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: config encodings, receiver states and the baud divisor helper.
// The transmitter uses the same encodings so one host register map drives both directions.
package uart_pkg;

   typedef enum logic [1:0] {
      PAR_NONE  = 2'b00,
      PAR_ODD   = 2'b01,
      PAR_EVEN  = 2'b10,
      PAR_NONE2 = 2'b11
   } parity_e;

   typedef enum logic [1:0] {
      B2400  = 2'b00,
      B4800  = 2'b01,
      B9600  = 2'b10,
      B19200 = 2'b11
   } baud_e;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } rx_state_e;

   localparam int DIV_W = 16;

   // Clocks per tick; only ever evaluated on constants so no divider is built.
   function automatic logic [DIV_W-1:0] baud_div(input int unsigned clk_hz,
                                                 input baud_e       baud,
                                                 input int unsigned ovs);
      int unsigned rate;
      case (baud)
         B2400:   rate = 2400;
         B4800:   rate = 4800;
         B9600:   rate = 9600;
         default: rate = 19200;
      endcase
      return DIV_W'(clk_hz / (rate * ovs));
   endfunction

endpackage

// File: rtl/uart_rx_baud_gen.sv
// Divisor counter producing a one-clock tick every i_div clocks.
// i_restart realigns the tick phase to the start edge of a frame.
module uart_rx_baud_gen
   import uart_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_restart,
   input  logic [DIV_W-1:0] i_div,
   output logic             o_tick
);

   logic [DIV_W-1:0] r_cnt;

   assign o_tick = (r_cnt == i_div - DIV_W'(1)) && !i_restart;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (i_restart || o_tick) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + DIV_W'(1);
      end
   end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 16x oversampling, 3-sample majority vote, optional odd/even parity.
// Frame status and the byte are registered together with a one-clock done pulse.
module uart_rx
   import uart_pkg::*;
#(
   parameter int unsigned CLK_FREQ_HZ = 100_000_000
)(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] parity_type,
   input  logic [1:0] baud_rate,
   input  logic       data_rx,
   output logic [7:0] data_out,
   output logic       active_flag,
   output logic       done_flag,
   output logic       parity_error,
   output logic       stop_error
);

   localparam int unsigned OVERSAMPLE = 16;
   localparam logic [DIV_W-1:0] DIV_2400  = baud_div(CLK_FREQ_HZ, B2400,  OVERSAMPLE);
   localparam logic [DIV_W-1:0] DIV_4800  = baud_div(CLK_FREQ_HZ, B4800,  OVERSAMPLE);
   localparam logic [DIV_W-1:0] DIV_9600  = baud_div(CLK_FREQ_HZ, B9600,  OVERSAMPLE);
   localparam logic [DIV_W-1:0] DIV_19200 = baud_div(CLK_FREQ_HZ, B19200, OVERSAMPLE);

   rx_state_e        r_state, w_next;
   logic             r_sync1, r_rxS, r_rxD;
   logic [3:0]       r_tcnt;
   logic [2:0]       r_bitIdx;
   logic             r_s7, r_s8;
   logic [7:0]       r_shift;
   logic             r_parErr;
   parity_e          r_parity;
   baud_e            r_baud;
   logic [7:0]       r_dataOut;
   logic             r_done, r_parityErr, r_stopErr;
   logic             w_fall, w_startDet, w_tick, w_vote, w_bit, w_parEn;
   logic [DIV_W-1:0] w_div;

   assign w_fall      = r_rxD & ~r_rxS;
   assign w_startDet  = (r_state == IDLE) && w_fall;
   assign w_vote      = w_tick && (r_tcnt == 4'd9) && (r_state != IDLE);
   assign w_bit       = (r_s7 & r_s8) | (r_s7 & r_rxS) | (r_s8 & r_rxS);
   assign w_parEn     = (r_parity == PAR_ODD) || (r_parity == PAR_EVEN);

   assign data_out     = r_dataOut;
   assign active_flag  = (r_state != IDLE);
   assign done_flag    = r_done;
   assign parity_error = r_parityErr;
   assign stop_error   = r_stopErr;

   always_comb begin
      w_div = DIV_19200;
      case (r_baud)
         B2400:   w_div = DIV_2400;
         B4800:   w_div = DIV_4800;
         B9600:   w_div = DIV_9600;
         default: w_div = DIV_19200;
      endcase
   end

   uart_rx_baud_gen u_baud (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_restart (w_startDet),
      .i_div     (w_div),
      .o_tick    (w_tick)
   );

   // Idle-high reset values keep a line held high from looking like a start edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1 <= 1'b1;
         r_rxS   <= 1'b1;
         r_rxD   <= 1'b1;
      end else begin
         r_sync1 <= data_rx;
         r_rxS   <= r_sync1;
         r_rxD   <= r_rxS;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (w_fall) w_next = START;
         START:   if (w_vote) w_next = w_bit ? IDLE : DATA;
         DATA:    if (w_vote && (r_bitIdx == 3'd7)) w_next = w_parEn ? PARITY : STOP;
         PARITY:  if (w_vote) w_next = STOP;
         STOP:    if (w_vote) w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // Stop-bit vote commits the frame and returns to IDLE mid stop bit for back-to-back frames.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tcnt      <= '0;
         r_bitIdx    <= '0;
         r_s7        <= 1'b1;
         r_s8        <= 1'b1;
         r_shift     <= '0;
         r_parErr    <= 1'b0;
         r_parity    <= PAR_NONE;
         r_baud      <= B2400;
         r_dataOut   <= '0;
         r_done      <= 1'b0;
         r_parityErr <= 1'b0;
         r_stopErr   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (w_startDet) begin
            r_tcnt   <= '0;
            r_bitIdx <= '0;
            r_parity <= parity_e'(parity_type);
            r_baud   <= baud_e'(baud_rate);
         end else if (w_tick && (r_state != IDLE)) begin
            r_tcnt <= r_tcnt + 4'd1;
         end
         if (w_tick && (r_state != IDLE) && (r_tcnt == 4'd7)) r_s7 <= r_rxS;
         if (w_tick && (r_state != IDLE) && (r_tcnt == 4'd8)) r_s8 <= r_rxS;
         if (w_vote) begin
            case (r_state)
               DATA: begin
                  r_shift  <= {w_bit, r_shift[7:1]};
                  r_bitIdx <= r_bitIdx + 3'd1;
               end
               PARITY: begin
                  r_parErr <= (r_parity == PAR_ODD) ? ~(^r_shift ^ w_bit) : (^r_shift ^ w_bit);
               end
               STOP: begin
                  r_dataOut   <= r_shift;
                  r_parityErr <= w_parEn ? r_parErr : 1'b0;
                  r_stopErr   <= ~w_bit;
                  r_done      <= 1'b1;
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 1.536 MHz: table of frames plus glitch, break and reset sequences.
module tb_uart_rx;

   localparam int unsigned CLK_HZ = 1_536_000;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [1:0] parity_type = 2'b00;
   logic [1:0] baud_rate = 2'b10;
   logic       data_rx = 1'b1;
   logic [7:0] data_out;
   logic       active_flag, done_flag, parity_error, stop_error;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [7:0] data;
      logic       par;
      logic       stop;
   } cap_t;
   cap_t capQ[$];
   logic prevDone = 1'b0;

   typedef struct {
      logic [1:0] par;
      logic [1:0] midPar;
      logic [1:0] baud;
      logic [7:0] data;
      logic       hasPar;
      logic       parBit;
      logic       stopBit;
      logic [7:0] expData;
      logic       expPar;
      logic       expStop;
   } vec_t;
   vec_t vecs[8];

   always #5 clk = ~clk;

   uart_rx #(.CLK_FREQ_HZ(CLK_HZ)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .parity_type  (parity_type),
      .baud_rate    (baud_rate),
      .data_rx      (data_rx),
      .data_out     (data_out),
      .active_flag  (active_flag),
      .done_flag    (done_flag),
      .parity_error (parity_error),
      .stop_error   (stop_error)
   );

   // Record every done pulse and flag any pulse wider than one clock.
   always @(negedge clk) begin
      if (done_flag) begin
         capQ.push_back('{data_out, parity_error, stop_error});
         checks++;
         if (prevDone) begin
            errors++;
            $display("[TB] FAIL doneWidth actual=2+ clks required=1 clk at %0t", $time);
         end
      end
      prevDone = done_flag;
   end

   function automatic int bitClks(input logic [1:0] baud);
      case (baud)
         2'b00:   return CLK_HZ / 2400;
         2'b01:   return CLK_HZ / 4800;
         2'b10:   return CLK_HZ / 9600;
         default: return CLK_HZ / 19200;
      endcase
   endfunction

   task automatic checkVal(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic sendBit(input logic b, input int clks);
      data_rx = b;
      repeat (clks) @(negedge clk);
   endtask

   task automatic applyStimulus(input logic [1:0] par, input logic [1:0] midPar,
                                input logic [1:0] baud, input logic [7:0] data,
                                input logic hasPar, input logic parBit,
                                input logic stopBit, input int stopClks);
      int bc;
      bc = bitClks(baud);
      parity_type = par;
      baud_rate   = baud;
      sendBit(1'b0, bc);
      checkVal("activeMid", {7'd0, active_flag}, 8'd1);
      parity_type = midPar;
      for (int i = 0; i < 8; i++) sendBit(data[i], bc);
      if (hasPar) sendBit(parBit, bc);
      sendBit(stopBit, stopClks);
   endtask

   task automatic checkOutput(input string name, input logic [7:0] expData,
                              input logic expPar, input logic expStop);
      int waited;
      cap_t c;
      waited = 0;
      while (capQ.size() == 0 && waited < 400) begin
         @(negedge clk);
         waited++;
      end
      checks++;
      if (capQ.size() == 0) begin
         errors++;
         $display("[TB] FAIL %s_done actual=no pulse required=pulse", name);
      end else begin
         c = capQ.pop_front();
         checkVal({name, "_data"}, c.data, expData);
         checkVal({name, "_parErr"}, {7'd0, c.par}, {7'd0, expPar});
         checkVal({name, "_stopErr"}, {7'd0, c.stop}, {7'd0, expStop});
      end
   endtask

   task automatic checkNoDone(input string name);
      checks++;
      if (capQ.size() != 0) begin
         errors++;
         $display("[TB] FAIL %s actual=%0d pulses required=0", name, capQ.size());
         capQ.delete();
      end
   endtask

   initial begin
      vecs[0] = '{2'b01, 2'b00, 2'b10, 8'h4A, 1'b1, 1'b0, 1'b1, 8'h4A, 1'b0, 1'b0};
      vecs[1] = '{2'b10, 2'b01, 2'b10, 8'hAA, 1'b1, 1'b1, 1'b1, 8'hAA, 1'b1, 1'b0};
      vecs[2] = '{2'b10, 2'b10, 2'b10, 8'h4A, 1'b1, 1'b1, 1'b1, 8'h4A, 1'b0, 1'b0};
      vecs[3] = '{2'b01, 2'b01, 2'b11, 8'h01, 1'b1, 1'b1, 1'b1, 8'h01, 1'b1, 1'b0};
      vecs[4] = '{2'b01, 2'b10, 2'b01, 8'h00, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0};
      vecs[5] = '{2'b00, 2'b01, 2'b10, 8'h55, 1'b0, 1'b0, 1'b0, 8'h55, 1'b0, 1'b1};
      vecs[6] = '{2'b11, 2'b00, 2'b11, 8'h0F, 1'b0, 1'b0, 1'b1, 8'h0F, 1'b0, 1'b0};
      vecs[7] = '{2'b10, 2'b00, 2'b01, 8'h80, 1'b1, 1'b1, 1'b1, 8'h80, 1'b0, 1'b0};

      repeat (3) @(negedge clk);
      checkVal("rst_data", data_out, 8'h00);
      checkVal("rst_active", {7'd0, active_flag}, 8'd0);
      checkVal("rst_done", {7'd0, done_flag}, 8'd0);
      checkVal("rst_parErr", {7'd0, parity_error}, 8'd0);
      checkVal("rst_stopErr", {7'd0, stop_error}, 8'd0);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);

      for (int v = 0; v < 8; v++) begin
         applyStimulus(vecs[v].par, vecs[v].midPar, vecs[v].baud, vecs[v].data,
                       vecs[v].hasPar, vecs[v].parBit, vecs[v].stopBit, bitClks(vecs[v].baud));
         sendBit(1'b1, 2 * bitClks(vecs[v].baud));
         checkOutput($sformatf("vec%0d", v), vecs[v].expData, vecs[v].expPar, vecs[v].expStop);
      end

      // Back-to-back frames; parity_type switches mid-frame and must only affect frame two.
      applyStimulus(2'b00, 2'b11, 2'b10, 8'hCC, 1'b0, 1'b0, 1'b1, 160);
      applyStimulus(2'b11, 2'b01, 2'b10, 8'hF0, 1'b0, 1'b0, 1'b1, 160);
      sendBit(1'b1, 320);
      checkOutput("b2b1", 8'hCC, 1'b0, 1'b0);
      checkOutput("b2b2", 8'hF0, 1'b0, 1'b0);
      checkNoDone("b2bExtra");

      // Start-bit glitch shorter than the vote window.
      data_rx = 1'b0;
      repeat (15) @(negedge clk);
      checkVal("glitchActive", {7'd0, active_flag}, 8'd1);
      repeat (15) @(negedge clk);
      data_rx = 1'b1;
      repeat (200) @(negedge clk);
      checkVal("glitchIdle", {7'd0, active_flag}, 8'd0);
      checkNoDone("glitchDone");
      checkVal("glitchData", data_out, 8'hF0);

      // Break: stop bit low and the line held low for 20 more bit times.
      applyStimulus(2'b00, 2'b00, 2'b10, 8'h55, 1'b0, 1'b0, 1'b0, 160 * 21);
      checkOutput("break", 8'h55, 1'b0, 1'b1);
      checkNoDone("breakRepeat");
      checkVal("breakIdle", {7'd0, active_flag}, 8'd0);
      sendBit(1'b1, 320);
      checkNoDone("breakRelease");

      // Reset in the middle of data bit 4.
      parity_type = 2'b00;
      sendBit(1'b0, 160);
      for (int i = 0; i < 4; i++) sendBit(i[0], 160);
      data_rx = 1'b1;
      repeat (80) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      checkVal("midRst_data", data_out, 8'h00);
      checkVal("midRst_active", {7'd0, active_flag}, 8'd0);
      checkVal("midRst_stopErr", {7'd0, stop_error}, 8'd0);
      checkVal("midRst_done", {7'd0, done_flag}, 8'd0);
      @(negedge clk);
      repeat (5) @(negedge clk);
      rst_n = 1'b1;
      sendBit(1'b1, 320);
      checkNoDone("midRstPartial");
      applyStimulus(2'b00, 2'b00, 2'b10, 8'h3C, 1'b0, 1'b0, 1'b1, 160);
      sendBit(1'b1, 160);
      checkOutput("afterRst", 8'h3C, 1'b0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
